// File: rtl/uart_rx_bit_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_sampler
//   Front end of the UART receiver. Synchronises the RX pin, detects a start
//   bit, tracks bit phase from the oversample tick and captures three samples
//   (MID-1, MID, MID+1) per bit for an external 3-input majority voter. The
//   voted value comes back on vote_in and is used to reject false starts and
//   to flag framing errors.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   tick_in         oversample enable (baud * OVERSAMPLE), one clk wide
//   rx_in           asynchronous serial line, idle high
//   vote_in         voter output for the current samp_a/b/c (combinational)
//   samp_a/b/c      early / centre / late sample of the current bit
//   samp_valid      one-clk strobe: a new complete triple is presented
//   samp_kind       0 = start, 1 = data, 2 = stop (valid with samp_valid)
//   bit_idx         data bit index (valid with samp_valid and kind = data)
//   busy            high while a frame is being received
//   false_start     one-clk pulse, start bit voted high
//   frame_err       one-clk pulse, stop bit voted low
// ---------------------------------------------------------------------------
module uart_rx_bit_sampler #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       rx_in,
    input  logic       vote_in,
    output logic       samp_a,
    output logic       samp_b,
    output logic       samp_c,
    output logic       samp_valid,
    output logic [1:0] samp_kind,
    output logic [3:0] bit_idx,
    output logic       busy,
    output logic       false_start,
    output logic       frame_err
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PH_A    = PW'(OVERSAMPLE/2 - 1);
    localparam logic [PW-1:0] PH_B    = PW'(OVERSAMPLE/2);
    localparam logic [PW-1:0] PH_C    = PW'(OVERSAMPLE/2 + 1);
    localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
    localparam logic [3:0]    IDX_LAST = 4'(DATA_BITS - 1);

    localparam logic [1:0] KIND_START = 2'd0;
    localparam logic [1:0] KIND_DATA  = 2'd1;
    localparam logic [1:0] KIND_STOP  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    state_t        state_q, state_d;
    logic          armed_q, armed_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [3:0]    idx_q, idx_d;        // running data bit counter
    logic          a_q, a_d, b_q, b_d, c_q, c_d;
    logic          valid_q, valid_d;
    logic [1:0]    kind_q, kind_d;      // kind of the presented triple
    logic [3:0]    oidx_q, oidx_d;      // bit index of the presented triple
    logic          fs_q, fs_d, fe_q, fe_d;

    assign rx_s = sync_q[SYNC_STAGES-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '1;
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            phase_q <= '0;
            idx_q   <= '0;
            a_q     <= 1'b1;
            b_q     <= 1'b1;
            c_q     <= 1'b1;
            valid_q <= 1'b0;
            kind_q  <= KIND_START;
            oidx_q  <= '0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_in};
            state_q <= state_d;
            armed_q <= armed_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            valid_q <= valid_d;
            kind_q  <= kind_d;
            oidx_q  <= oidx_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        valid_d = 1'b0;
        kind_d  = kind_q;
        oidx_d  = oidx_q;
        fs_d    = 1'b0;
        fe_d    = 1'b0;

        if (tick_in) begin
            if (state_q == S_IDLE) begin
                // Start detection requires a high tick first, so a line stuck
                // low cannot retrigger after a frame ends.
                if (rx_s) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_START;
                    phase_d = PW'(1);
                    armed_d = 1'b0;
                end
            end else begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
                if (phase_q == PH_A) a_d = rx_s;
                if (phase_q == PH_B) b_d = rx_s;
                if (phase_q == PH_C) begin
                    c_d     = rx_s;
                    valid_d = 1'b1;
                    oidx_d  = idx_q;
                    case (state_q)
                        S_START: kind_d = KIND_START;
                        S_DATA:  kind_d = KIND_DATA;
                        default: kind_d = KIND_STOP;
                    endcase
                end
                if (phase_q == PH_LAST) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                            idx_d   = '0;
                        end
                        S_DATA: begin
                            if (idx_q == IDX_LAST) state_d = S_STOP;
                            else                   idx_d   = idx_q + 4'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Voted decisions on the presented triple. Keyed on the triple's kind
        // rather than the live state, which may already have moved on when
        // MID+1 coincides with the last phase of the bit.
        if (valid_q) begin
            if (kind_q == KIND_START && vote_in) begin
                fs_d    = 1'b1;
                state_d = S_IDLE;
                phase_d = '0;
            end else if (kind_q == KIND_STOP) begin
                // Leave mid stop bit so the next start edge is caught early.
                fe_d    = ~vote_in;
                state_d = S_IDLE;
                phase_d = '0;
                armed_d = 1'b0;
            end
        end
    end

    // Outputs
    always_comb begin
        busy        = (state_q != S_IDLE);
        samp_a      = a_q;
        samp_b      = b_q;
        samp_c      = c_q;
        samp_valid  = valid_q;
        samp_kind   = kind_q;
        bit_idx     = oidx_q;
        false_start = fs_q;
        frame_err   = fe_q;
    end

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
module tb_uart_rx_bit_sampler;
    localparam int OS  = 16;
    localparam int DB  = 8;
    localparam int MID = OS / 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic       rx_in = 1'b1;
    logic       vote_in;
    logic       samp_a, samp_b, samp_c, samp_valid;
    logic [1:0] samp_kind;
    logic [3:0] bit_idx;
    logic       busy, false_start, frame_err;

    uart_rx_bit_sampler #(.OVERSAMPLE(OS), .DATA_BITS(DB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .tick_in(tick_in), .rx_in(rx_in), .vote_in(vote_in),
        .samp_a(samp_a), .samp_b(samp_b), .samp_c(samp_c), .samp_valid(samp_valid),
        .samp_kind(samp_kind), .bit_idx(bit_idx), .busy(busy),
        .false_start(false_start), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream majority voter
    assign vote_in = (samp_a & samp_b) | (samp_a & samp_c) | (samp_b & samp_c);

    typedef struct {
        logic [2:0] abc;
        logic [1:0] kind;
        int         idx;
        logic       fs;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    bit   line[$];     // line level seen at each tick
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- line construction ----------------
    task automatic add_idle(input int n);
        repeat (n) line.push_back(1'b1);
    endtask

    task automatic add_bit(input bit v);
        repeat (OS) line.push_back(v);
    endtask

    task automatic add_frame(input logic [8:0] d, input bit stop);
        add_bit(1'b0);
        for (int i = 0; i < DB; i++) add_bit(d[i]);
        add_bit(stop);
    endtask

    // ---------------- reference model ----------------
    // Scans the whole tick-level line: a start is a low tick after at least
    // one high tick; each bit j of the frame is sampled at ticks
    // t0 + j*OS + MID-1 .. MID+1. The receiver is idle again from the tick
    // after the start (false start) or stop sample, with the arm cleared.
    task automatic run_model();
        int n;
        int t;
        bit armed;
        n = line.size();
        t = 0;
        armed = 1'b0;
        while (t < n) begin
            if (line[t]) begin
                armed = 1'b1;
                t++;
            end else if (!armed) begin
                t++;
            end else begin
                int t0;
                t0 = t;
                armed = 1'b0;
                t = n;
                for (int j = 0; j <= DB + 1; j++) begin
                    int   c;
                    bit   v;
                    exp_t e;
                    c = t0 + j * OS + MID;
                    if (c + 1 >= n) break;
                    e.abc  = {line[c-1], line[c], line[c+1]};
                    v      = (line[c-1] & line[c]) | (line[c-1] & line[c+1]) | (line[c] & line[c+1]);
                    e.kind = (j == 0) ? 2'd0 : (j == DB + 1) ? 2'd2 : 2'd1;
                    e.idx  = j - 1;
                    e.fs   = (j == 0) && v;
                    e.fe   = (j == DB + 1) && !v;
                    exp_q.push_back(e);
                    if (e.fs || j == DB + 1) begin
                        t = c + 2;
                        break;
                    end
                end
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        tick_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_line();
        for (int i = 0; i < line.size(); i++) begin
            @(negedge clk);
            rx_in = line[i];
            tick_in = 1'b0;
            repeat (2) @(negedge clk);
            tick_in = 1'b1;
            @(negedge clk);
            tick_in = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
        chk("drain_outstanding", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run_segment();
        do_reset();
        run_model();
        drive_line();
        drain();
        line.delete();
    endtask

    // ---------------- monitor ----------------
    bit   pend = 1'b0;
    exp_t pe;
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                chk("false_start", 32'(false_start), 32'(pe.fs));
                chk("frame_err", 32'(frame_err), 32'(pe.fe));
                if (pe.fs || pe.kind == 2'd2) chk("busy_after_exit", 32'(busy), 32'd0);
                pend = 1'b0;
            end else if (false_start || frame_err) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got fs=%0b fe=%0b expected 0 at %0t",
                         false_start, frame_err, $time);
            end
            if (samp_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got kind=%0d idx=%0d expected none at %0t",
                             samp_kind, bit_idx, $time);
                end else begin
                    pe = exp_q.pop_front();
                    chk("triple", 32'({samp_a, samp_b, samp_c}), 32'(pe.abc));
                    chk("kind", 32'(samp_kind), 32'(pe.kind));
                    if (pe.kind == 2'd1) chk("bit_idx", 32'(bit_idx), 32'(pe.idx));
                    chk("busy_in_frame", 32'(busy), 32'd1);
                    pend = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int gi;
        // Reset state
        do_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abc", 32'({samp_a, samp_b, samp_c}), 32'b111);
        chk("rst_valid", 32'(samp_valid), 32'd0);
        chk("rst_kind", 32'(samp_kind), 32'd0);
        chk("rst_idx", 32'(bit_idx), 32'd0);

        // Clean 0x55 frame
        add_idle(20); add_frame(9'h55, 1'b1); add_idle(20);
        run_segment();

        // 3-tick low glitch on idle line
        add_idle(20); line.push_back(1'b0); line.push_back(1'b0); line.push_back(1'b0); add_idle(40);
        run_segment();

        // 1-tick low glitch at MID of data bit 3 (bit is high)
        add_idle(20); add_frame(9'h5C, 1'b1); add_idle(20);
        gi = 20 + 4 * OS + MID;
        line[gi] = 1'b0;
        run_segment();

        // Low stop bit, then idle and a clean frame
        add_idle(20); add_frame(9'hA7, 1'b0); add_idle(20); add_frame(9'h3C, 1'b1); add_idle(20);
        run_segment();

        // Line stuck low for 40 bit times after a frame with low stop bit
        add_idle(20); add_frame(9'h81, 1'b0);
        repeat (40) add_bit(1'b0);
        add_idle(20); add_frame(9'h6E, 1'b1); add_idle(20);
        run_segment();

        // Random frames with random gaps, stop errors and single-tick flips
        repeat (3) begin
            add_idle(10);
            repeat (5) begin
                add_idle($urandom_range(0, 30));
                add_frame(9'($urandom), ($urandom_range(0, 5) != 0));
                if ($urandom_range(0, 1) == 1) begin
                    gi = $urandom_range(0, line.size() - 1);
                    line[gi] = ~line[gi];
                end
            end
            add_idle(20);
            run_segment();
        end

        // Reset in the middle of data bit 4
        do_reset();
        add_idle(10); add_bit(1'b0);
        for (int i = 0; i < 4; i++) add_bit(i[0]);
        repeat (5) line.push_back(1'b1);
        run_model();
        drive_line();
        drain();
        line.delete();
        chk("midframe_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_abc", 32'({samp_a, samp_b, samp_c}), 32'b111);
        chk("midrst_valid", 32'(samp_valid), 32'd0);
        chk("midrst_pulses", 32'({false_start, frame_err}), 32'd0);
        @(negedge clk);
        chk("midrst_pulses2", 32'({false_start, frame_err, samp_valid}), 32'd0);

        // Frame after reset decodes normally
        add_idle(20); add_frame(9'hC3, 1'b1); add_idle(20);
        run_segment();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_rx_bit_sampler.md
Name: uart_rx_bit_sampler

Overview:
- Front end of the UART receiver, directly upstream of the 3-input majority voter (`generic__maj3`).
- Synchronises the raw RX pin, detects a start bit, and tracks bit phase from an oversample tick.
- Captures three samples around the centre of each bit and presents them to the voter as A/B/C.
- Reads the voted result back on `vote_in` to reject false starts and flag framing errors.
- The downstream shift register consumes `samp_valid`, `samp_kind` and `bit_idx` alongside the voter output.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; even, >= 4.
- DATA_BITS, 8, data bits per frame; 5..9.
- SYNC_STAGES, 2, RX synchroniser flops; >= 2.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- tick_in  input  1  oversample enable, one clk wide, rate = baud*OVERSAMPLE.
- rx_in  input  1  asynchronous serial line, idle high.
- vote_in  input  1  majority-voter output for the current samp_a/b/c (combinational return path).
- samp_a  output  1  early sample (phase MID-1).
- samp_b  output  1  centre sample (phase MID).
- samp_c  output  1  late sample (phase MID+1).
- samp_valid  output  1  one-clk strobe: samp_a/b/c form a complete new triple.
- samp_kind  output  2  0=start, 1=data, 2=stop; 3 never driven.
- bit_idx  output  4  data bit index 0..DATA_BITS-1, valid with kind=data.
- busy  output  1  high in START/DATA/STOP.
- false_start  output  1  one-clk pulse.
- frame_err  output  1  one-clk pulse.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. Every flop takes its reset value on the clk edge where `rst` = 1; `rst` overrides all other inputs.
- Reset values:
  - Synchroniser chain = 1; samp_a/b/c = 1.
  - samp_valid, false_start, frame_err, busy = 0.
  - samp_kind = 0; bit_idx = 0; phase = 0.
  - State = IDLE; armed = 0.
- Timing basis:
  - rx_s is the last synchroniser stage.
  - MID = OVERSAMPLE/2.
  - The phase counter advances only on tick_in and wraps OVERSAMPLE-1 -> 0.
- IDLE:
  - A tick with rx_s = 1 sets armed.
  - A tick with rx_s = 0 while armed: go to START, phase = 1, armed = 0, busy = 1 next cycle.
  - If not armed, rx_s = 0 is ignored. A line stuck low therefore never retriggers.
- Sampling (START/DATA/STOP):
  - On the tick where phase = MID-1, capture rx_s into samp_a.
  - On the tick where phase = MID, capture rx_s into samp_b.
  - On the tick where phase = MID+1, capture rx_s into samp_c.
  - samp_valid is asserted in the clk cycle after the MID+1 tick (registered, latency 1 clk), together with samp_kind and bit_idx.
  - samp_a/b/c hold their values until the next capture.
- Decisions, evaluated in the samp_valid cycle using vote_in:
  - START, vote_in = 1: pulse false_start, go to IDLE, busy = 0.
  - START, vote_in = 0: stay in START until the tick at phase OVERSAMPLE-1, then go to DATA with bit_idx = 0.
  - DATA: on each tick at phase OVERSAMPLE-1, increment bit_idx. After bit DATA_BITS-1 completes, go to STOP.
  - STOP: pulse frame_err if vote_in = 0. Go to IDLE in the following cycle (mid-stop-bit exit allows early resync), busy = 0.
- Simultaneous events:
  - tick_in and samp_valid in the same cycle: both are honoured.
  - The phase counter never skips or double-counts.
- Non-tick cycles: no state change except expiry of the samp_valid, false_start and frame_err pulses.
- Reset mid-frame: immediate return to reset values. No valid or error pulse is emitted.

Test Plan:
- Frame 0x55, 8N1, OVERSAMPLE = 16, clean line.
  - Expect 10 samp_valid strobes: kind 0, then eight kind 1 with bit_idx 0..7, then kind 2.
  - Expect triples 000, then 111/000 alternating LSB first, then 111 on the stop bit.
  - No false_start or frame_err; busy deasserts after the stop strobe.
- 3-tick low glitch on an idle line (ticks 0..2): start triple = 111, false_start pulses once, state returns to IDLE, busy = 0 one cycle later.
- 1-tick low glitch at phase MID of data bit 3 (line high): triple 101 on bit_idx 3; no error.
- Frame with stop bit driven low: stop triple 000, frame_err pulses 1 clk after the stop samp_valid. A following clean frame after the line idles high decodes normally.
- Line held low for 40 bit times after a frame: no new START until rx_s has been 1 on at least one tick.
- rst asserted at bit_idx 4: next cycle busy = 0, samp_a/b/c = 1, no pulses. A subsequent frame decodes correctly.
